short_stack_unit: RTL and testbench

SHORT_STACK_UNIT -- requirements
Module: short_stack_unit

---
 rtl/short_stack_unit.sv | 206 ++++++++++++++++++++
 tb/tb_short_stack_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/short_stack_unit.sv
// short_stack_unit
//   Per-ray short traversal stack with restart support. Traversal requests
//   push entries, record a restart node and a maximum scene distance, or pop.
//   A pop returns the top stack entry, a restart (restnode or root), or hands
//   the ray to the shader when there is no more work.
//
// Ports
//   clk                 clock
//   rst                 asynchronous active-low reset
//   trav_to_ss_valid    request valid
//   trav_to_ss_data     request payload (trav_to_ss_t)
//   trav_to_ss_stall    request not accepted this cycle
//   ss_to_tarb_valid    pop / restart result valid
//   ss_to_tarb_data     pop / restart result (tarb_t)
//   ss_to_tarb_stall    backpressure from the traversal arbiter
//   ss_to_shader_valid  ray finished
//   ss_to_shader_data   finished ray identity (shader_t)
//   ss_to_shader_stall  backpressure from the shader

package short_stack_pkg;
  localparam int SS_RAYID_W = 9;
  localparam int NODE_W     = 32;

  typedef struct packed {
    logic [SS_RAYID_W-1:0] rayID;
    logic                  is_shadow;
    logic [1:0]            ss_wptr;
    logic [2:0]            ss_num;
  } ray_info_t;

  typedef struct packed {
    ray_info_t         ray_info;
    logic              push_req;
    logic [NODE_W-1:0] push_node_ID;
    logic              update_restnode_req;
    logic [NODE_W-1:0] rest_node_ID;
    logic [31:0]       t_max;
    logic              pop_req;
    logic              update_maxscene_req;
  } trav_to_ss_t;

  typedef struct packed {
    ray_info_t         ray_info;
    logic [NODE_W-1:0] nodeID;
    logic              restnode_search;
    logic [31:0]       t_max;
    logic [31:0]       t_min;
  } tarb_t;

  typedef struct packed {
    logic [SS_RAYID_W-1:0] rayID;
    logic                  is_shadow;
  } shader_t;

  typedef struct packed {
    logic [NODE_W-1:0] nodeID;
    logic [31:0]       t_max;
  } ss_entry_t;
endpackage

module short_stack_unit
  import short_stack_pkg::*;
#(
  parameter int NUM_RAYS = 512,
  parameter int SS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trav_to_ss_valid,
  input  trav_to_ss_t trav_to_ss_data,
  output logic        trav_to_ss_stall,
  output logic        ss_to_tarb_valid,
  output tarb_t       ss_to_tarb_data,
  input  logic        ss_to_tarb_stall,
  output logic        ss_to_shader_valid,
  output shader_t     ss_to_shader_data,
  input  logic        ss_to_shader_stall
);

  localparam int RAYID_W = $clog2(NUM_RAYS);
  localparam int SS_AW   = $clog2(SS_DEPTH);

  // storage
  ss_entry_t         stack_mem [NUM_RAYS*SS_DEPTH];
  logic [NODE_W-1:0] rest_mem  [NUM_RAYS];
  logic [31:0]       ms_mem    [NUM_RAYS];
  logic [NUM_RAYS-1:0] rv_bits;
  logic [NUM_RAYS-1:0] mv_bits;

  // stage 1
  logic        s1_valid;
  logic        s1_pop;
  ray_info_t   s1_info;
  logic [31:0] s1_tmax;
  ss_entry_t   rd_entry;
  logic [NODE_W-1:0] rd_rest;
  logic [31:0] rd_ms;

  logic                     in_fire;
  logic [RAYID_W-1:0]       in_ray;
  logic [SS_AW-1:0]         push_ptr;
  logic [SS_AW-1:0]         pop_ptr;
  logic [RAYID_W-1:0]       s1_ray;
  logic                     stk_hit;
  logic                     done;
  logic                     dest_blocked;
  logic                     s1_adv;
  logic                     tarb_load;
  logic                     shd_load;
  tarb_t                    tarb_next;

  assign in_ray   = trav_to_ss_data.ray_info.rayID[RAYID_W-1:0];
  assign push_ptr = trav_to_ss_data.ray_info.ss_wptr[SS_AW-1:0];
  assign pop_ptr  = push_ptr - SS_AW'(1);
  assign s1_ray   = s1_info.rayID[RAYID_W-1:0];

  // stage 2: classify the pop and build the arbiter result
  always_comb begin
    stk_hit   = (s1_info.ss_num != 3'd0);
    done      = !stk_hit && (!mv_bits[s1_ray] || (s1_tmax >= rd_ms));
    tarb_next = '0;
    tarb_next.ray_info = s1_info;
    tarb_next.t_min    = s1_tmax;
    if (stk_hit) begin
      tarb_next.ray_info.ss_wptr = s1_info.ss_wptr - 2'd1;
      tarb_next.ray_info.ss_num  = s1_info.ss_num - 3'd1;
      tarb_next.nodeID           = rd_entry.nodeID;
      tarb_next.t_max            = rd_entry.t_max;
      tarb_next.restnode_search  = 1'b0;
    end else begin
      tarb_next.nodeID          = rv_bits[s1_ray] ? rd_rest : '0;
      tarb_next.t_max           = rd_ms;
      tarb_next.restnode_search = 1'b1;
    end
  end

  // Only a pop whose own destination buffer is full and stalled blocks the
  // pipe; the buffer can take new data in the same cycle it is drained.
  assign dest_blocked     = done ? (ss_to_shader_valid && ss_to_shader_stall)
                                 : (ss_to_tarb_valid && ss_to_tarb_stall);
  assign trav_to_ss_stall = s1_valid && s1_pop && dest_blocked;
  assign in_fire          = trav_to_ss_valid && !trav_to_ss_stall;
  assign s1_adv           = s1_valid && !trav_to_ss_stall;
  assign tarb_load        = s1_adv && s1_pop && !done;
  assign shd_load         = s1_adv && s1_pop && done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid           <= 1'b0;
      ss_to_tarb_valid   <= 1'b0;
      ss_to_shader_valid <= 1'b0;
      rv_bits            <= '0;
      mv_bits            <= '0;
    end else begin
      if (in_fire)
        s1_valid <= 1'b1;
      else if (!trav_to_ss_stall)
        s1_valid <= 1'b0;

      if (tarb_load)
        ss_to_tarb_valid <= 1'b1;
      else if (!ss_to_tarb_stall)
        ss_to_tarb_valid <= 1'b0;

      if (shd_load)
        ss_to_shader_valid <= 1'b1;
      else if (!ss_to_shader_stall)
        ss_to_shader_valid <= 1'b0;

      // a finishing ray is never the ray being updated this cycle
      if (shd_load) begin
        rv_bits[s1_ray] <= 1'b0;
        mv_bits[s1_ray] <= 1'b0;
      end
      if (in_fire && trav_to_ss_data.update_restnode_req)
        rv_bits[in_ray] <= 1'b1;
      if (in_fire && trav_to_ss_data.update_maxscene_req)
        mv_bits[in_ray] <= 1'b1;
    end
  end

  // RAM/table writes and registered reads; read data is only captured on
  // acceptance so it stays aligned with a stage-1 pop that is held.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (trav_to_ss_data.push_req)
        stack_mem[{in_ray, push_ptr}] <= '{nodeID: trav_to_ss_data.push_node_ID,
                                           t_max:  trav_to_ss_data.t_max};
      if (trav_to_ss_data.update_restnode_req)
        rest_mem[in_ray] <= trav_to_ss_data.rest_node_ID;
      if (trav_to_ss_data.update_maxscene_req)
        ms_mem[in_ray] <= trav_to_ss_data.t_max;
      rd_entry <= stack_mem[{in_ray, pop_ptr}];
      rd_rest  <= rest_mem[in_ray];
      rd_ms    <= ms_mem[in_ray];
      s1_info  <= trav_to_ss_data.ray_info;
      s1_tmax  <= trav_to_ss_data.t_max;
      s1_pop   <= trav_to_ss_data.pop_req;
    end
    if (tarb_load)
      ss_to_tarb_data <= tarb_next;
    if (shd_load)
      ss_to_shader_data <= '{rayID: s1_info.rayID, is_shadow: s1_info.is_shadow};
  end

endmodule

// File: tb/tb_short_stack_unit.sv
// Bench for short_stack_unit: directed scenarios followed by randomized
// traffic, checked against a queue-based model of the per-ray stacks.
module tb_short_stack_unit;
  import short_stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trav_to_ss_valid = 1'b0;
  trav_to_ss_t trav_to_ss_data = '0;
  logic        trav_to_ss_stall;
  logic        ss_to_tarb_valid;
  tarb_t       ss_to_tarb_data;
  logic        ss_to_tarb_stall = 1'b0;
  logic        ss_to_shader_valid;
  shader_t     ss_to_shader_data;
  logic        ss_to_shader_stall = 1'b0;

  always #5 clk = ~clk;

  short_stack_unit #(.NUM_RAYS(512), .SS_DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .trav_to_ss_valid   (trav_to_ss_valid),
    .trav_to_ss_data    (trav_to_ss_data),
    .trav_to_ss_stall   (trav_to_ss_stall),
    .ss_to_tarb_valid   (ss_to_tarb_valid),
    .ss_to_tarb_data    (ss_to_tarb_data),
    .ss_to_tarb_stall   (ss_to_tarb_stall),
    .ss_to_shader_valid (ss_to_shader_valid),
    .ss_to_shader_data  (ss_to_shader_data),
    .ss_to_shader_stall (ss_to_shader_stall)
  );

  // reference model
  ss_entry_t   m_stk  [512][$];
  bit          m_mv   [512];
  bit          m_rv   [512];
  logic [31:0] m_ms   [512];
  logic [31:0] m_rest [512];
  logic [1:0]  m_wptr [512];
  tarb_t       exp_tarb[$];
  shader_t     exp_shd[$];

  int      checks = 0;
  int      failures = 0;
  bit      last_acc = 1'b0;
  bit      rand_mode = 1'b0;
  bit      tarb_held = 1'b0;
  bit      shd_held = 1'b0;
  tarb_t   held_tarb;
  shader_t held_shd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) begin
      m_mv[i] = 1'b0;
      m_rv[i] = 1'b0;
      m_wptr[i] = 2'd0;
      m_stk[i].delete();
    end
    exp_tarb.delete();
    exp_shd.delete();
    tarb_held = 1'b0;
    shd_held = 1'b0;
  endtask

  // Stack modelled as a bounded LIFO: newest at the back, oldest dropped on overflow.
  task automatic model_accept(input trav_to_ss_t r);
    int ray;
    ss_entry_t e;
    tarb_t t;
    shader_t s;
    ray = int'(r.ray_info.rayID);
    if (r.pop_req) begin
      t = '0;
      t.ray_info = r.ray_info;
      t.t_min = r.t_max;
      if (r.ray_info.ss_num != 0) begin
        e = m_stk[ray].pop_back();
        t.ray_info.ss_wptr = r.ray_info.ss_wptr - 2'd1;
        t.ray_info.ss_num  = r.ray_info.ss_num - 3'd1;
        t.nodeID = e.nodeID;
        t.t_max = e.t_max;
        t.restnode_search = 1'b0;
        exp_tarb.push_back(t);
      end else if (!m_mv[ray] || r.t_max >= m_ms[ray]) begin
        s.rayID = r.ray_info.rayID;
        s.is_shadow = r.ray_info.is_shadow;
        exp_shd.push_back(s);
        m_mv[ray] = 1'b0;
        m_rv[ray] = 1'b0;
      end else begin
        t.nodeID = m_rv[ray] ? m_rest[ray] : 32'd0;
        t.t_max = m_ms[ray];
        t.restnode_search = 1'b1;
        exp_tarb.push_back(t);
      end
    end else begin
      if (r.push_req) begin
        e.nodeID = r.push_node_ID;
        e.t_max = r.t_max;
        m_stk[ray].push_back(e);
        if (m_stk[ray].size() > 4) void'(m_stk[ray].pop_front());
      end
      if (r.update_restnode_req) begin
        m_rest[ray] = r.rest_node_ID;
        m_rv[ray] = 1'b1;
      end
      if (r.update_maxscene_req) begin
        m_ms[ray] = r.t_max;
        m_mv[ray] = 1'b1;
      end
    end
  endtask

  // One clock: entered just after a negedge with inputs already driven.
  task automatic tick();
    tarb_t et;
    shader_t es;
    #2;
    last_acc = trav_to_ss_valid && !trav_to_ss_stall;
    if (last_acc) model_accept(trav_to_ss_data);

    if (tarb_held) begin
      chk("tarb_hold_valid", 128'(ss_to_tarb_valid), 128'(1));
      chk("tarb_hold_data", 128'(ss_to_tarb_data), 128'(held_tarb));
    end
    if (ss_to_tarb_valid === 1'b1 && !ss_to_tarb_stall) begin
      if (exp_tarb.size() == 0) chk("tarb_unexpected", 128'(ss_to_tarb_valid), 128'(0));
      else begin
        et = exp_tarb.pop_front();
        chk("tarb_data", 128'(ss_to_tarb_data), 128'(et));
      end
    end
    tarb_held = (ss_to_tarb_valid === 1'b1) && ss_to_tarb_stall;
    held_tarb = ss_to_tarb_data;

    if (shd_held) begin
      chk("shd_hold_valid", 128'(ss_to_shader_valid), 128'(1));
      chk("shd_hold_data", 128'(ss_to_shader_data), 128'(held_shd));
    end
    if (ss_to_shader_valid === 1'b1 && !ss_to_shader_stall) begin
      if (exp_shd.size() == 0) chk("shd_unexpected", 128'(ss_to_shader_valid), 128'(0));
      else begin
        es = exp_shd.pop_front();
        chk("shd_data", 128'(ss_to_shader_data), 128'(es));
      end
    end
    shd_held = (ss_to_shader_valid === 1'b1) && ss_to_shader_stall;
    held_shd = ss_to_shader_data;

    @(posedge clk);
    @(negedge clk);
    if (rand_mode) begin
      ss_to_tarb_stall   = ($urandom_range(0, 9) < 4);
      ss_to_shader_stall = ($urandom_range(0, 9) < 4);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input trav_to_ss_t r);
    int n;
    n = 0;
    trav_to_ss_data = r;
    trav_to_ss_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 60);
    if (!last_acc) chk("send_timeout", 128'(trav_to_ss_stall), 128'(0));
    trav_to_ss_valid = 1'b0;
    trav_to_ss_data = '0;
  endtask

  function automatic trav_to_ss_t req_base(input int ray, input int wptr, input int num,
                                           input logic [31:0] tmax);
    trav_to_ss_t r;
    r = '0;
    r.ray_info.rayID = 9'(ray);
    r.ray_info.ss_wptr = 2'(wptr);
    r.ray_info.ss_num = 3'(num);
    r.t_max = tmax;
    return r;
  endfunction

  function automatic trav_to_ss_t req_push(input int ray, input int wptr, input int num,
                                           input logic [31:0] node, input logic [31:0] tmax);
    trav_to_ss_t r;
    r = req_base(ray, wptr, num, tmax);
    r.push_req = 1'b1;
    r.push_node_ID = node;
    return r;
  endfunction

  function automatic trav_to_ss_t req_pop(input int ray, input int wptr, input int num,
                                          input logic [31:0] tmax);
    trav_to_ss_t r;
    r = req_base(ray, wptr, num, tmax);
    r.pop_req = 1'b1;
    return r;
  endfunction

  function automatic trav_to_ss_t req_ms(input int ray, input logic [31:0] tmax);
    trav_to_ss_t r;
    r = req_base(ray, 0, 0, tmax);
    r.update_maxscene_req = 1'b1;
    return r;
  endfunction

  function automatic trav_to_ss_t req_rest(input int ray, input logic [31:0] node);
    trav_to_ss_t r;
    r = req_base(ray, 0, 0, 32'd0);
    r.update_restnode_req = 1'b1;
    r.rest_node_ID = node;
    return r;
  endfunction

  function automatic tarb_t mk_tarb(input int ray, input int wptr, input int num,
                                    input logic [31:0] node, input bit rs,
                                    input logic [31:0] tmax, input logic [31:0] tmin);
    tarb_t t;
    t = '0;
    t.ray_info.rayID = 9'(ray);
    t.ray_info.ss_wptr = 2'(wptr);
    t.ray_info.ss_num = 3'(num);
    t.nodeID = node;
    t.restnode_search = rs;
    t.t_max = tmax;
    t.t_min = tmin;
    return t;
  endfunction

  function automatic logic [31:0] tval();
    return {1'b0, 3'($urandom_range(0, 7)), 28'h0};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    shader_t s_exp;
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tarb_valid", 128'(ss_to_tarb_valid), 128'(0));
    chk("rst_shd_valid", 128'(ss_to_shader_valid), 128'(0));
    chk("rst_stall", 128'(trav_to_ss_stall), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    // single push then pop, with two-cycle latency
    send(req_push(5, 3, 0, 32'h12, 32'h4000_0000));
    idle(3);
    send(req_pop(5, 0, 1, 32'h3F80_0000));
    #1 chk("pop_lat_a1", 128'(ss_to_tarb_valid), 128'(0));
    tick();
    #1 chk("pop_lat_a2", 128'(ss_to_tarb_valid), 128'(1));
    chk("pop_data", 128'(ss_to_tarb_data),
        128'(mk_tarb(5, 3, 0, 32'h12, 1'b0, 32'h4000_0000, 32'h3F80_0000)));
    idle(3);

    // restart from the recorded restnode
    send(req_ms(7, 32'h4120_0000));
    idle(3);
    send(req_rest(7, 32'h30));
    idle(3);
    send(req_pop(7, 0, 0, 32'h40A0_0000));
    tick();
    #1 chk("restart_valid", 128'(ss_to_tarb_valid), 128'(1));
    chk("restart_data", 128'(ss_to_tarb_data),
        128'(mk_tarb(7, 0, 0, 32'h30, 1'b1, 32'h4120_0000, 32'h40A0_0000)));
    idle(3);

    // t_max equal to maxscene finishes the ray; valid bits then cleared
    send(req_pop(7, 0, 0, 32'h4120_0000));
    tick();
    s_exp.rayID = 9'd7;
    s_exp.is_shadow = 1'b0;
    #1 chk("done_valid", 128'(ss_to_shader_valid), 128'(1));
    chk("done_data", 128'(ss_to_shader_data), 128'(s_exp));
    idle(3);
    send(req_pop(7, 0, 0, 32'h0000_0001));
    tick();
    #1 chk("done_again_shd", 128'(ss_to_shader_valid), 128'(1));
    chk("done_again_tarb", 128'(ss_to_tarb_valid), 128'(0));
    idle(3);

    // five pushes wrap the four-entry stack
    for (int i = 0; i < 5; i++) begin
      send(req_push(1, i % 4, (i < 4) ? i : 4, 32'h100 + 32'(i), 32'h3F00_0000 + 32'(i)));
      idle(3);
    end
    send(req_pop(1, 1, 4, 32'h3E00_0000));
    tick();
    #1 chk("wrap_data", 128'(ss_to_tarb_data),
           128'(mk_tarb(1, 0, 3, 32'h104, 1'b0, 32'h3F00_0004, 32'h3E00_0000)));
    idle(3);

    // downstream stall with two pops in flight
    send(req_push(20, 0, 0, 32'h200, 32'h4100_0000));
    send(req_push(21, 0, 0, 32'h210, 32'h4110_0000));
    idle(3);
    ss_to_tarb_stall = 1'b1;
    send(req_pop(20, 1, 1, 32'h3000_0000));
    send(req_pop(21, 1, 1, 32'h3010_0000));
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp_upstream_stall", 128'(trav_to_ss_stall), 128'(1));
      chk("bp_first_node", 128'(ss_to_tarb_data.nodeID), 128'(32'h200));
      tick();
    end
    ss_to_tarb_stall = 1'b0;
    idle(4);
    chk("bp_drained", 128'(exp_tarb.size()), 128'(0));

    // reset while an output is held
    send(req_ms(9, 32'h4200_0000));
    idle(3);
    send(req_rest(9, 32'h99));
    idle(3);
    send(req_push(30, 0, 0, 32'h300, 32'h4000_0000));
    idle(3);
    ss_to_tarb_stall = 1'b1;
    send(req_pop(30, 1, 1, 32'h3F00_0000));
    idle(2);
    #1 chk("pre_rst_valid", 128'(ss_to_tarb_valid), 128'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_tarb", 128'(ss_to_tarb_valid), 128'(0));
    chk("mid_rst_shd", 128'(ss_to_shader_valid), 128'(0));
    chk("mid_rst_stall", 128'(trav_to_ss_stall), 128'(0));
    model_reset();
    ss_to_tarb_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send(req_pop(9, 0, 0, 32'h0000_0001));
    tick();
    #1 chk("post_rst_done", 128'(ss_to_shader_valid), 128'(1));
    idle(3);
    send(req_ms(9, 32'h4200_0000));
    idle(3);
    send(req_pop(9, 0, 0, 32'h3F80_0000));
    tick();
    #1 chk("post_rst_root", 128'(ss_to_tarb_data),
           128'(mk_tarb(9, 0, 0, 32'h0, 1'b1, 32'h4200_0000, 32'h3F80_0000)));
    idle(3);

    // randomized traffic over four rays in rotation
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int ray;
      int op;
      int n;
      trav_to_ss_t r;
      ray = 100 + (i % 4);
      op = $urandom_range(0, 9);
      if (op < 4) begin
        n = m_stk[ray].size();
        r = req_push(ray, int'(m_wptr[ray]), (n < 4) ? n : 4, $urandom, tval());
        if ($urandom_range(0, 2) == 0) begin
          r.update_restnode_req = 1'b1;
          r.rest_node_ID = $urandom;
        end
        m_wptr[ray] = m_wptr[ray] + 2'd1;
      end else if (op < 6) begin
        r = req_ms(ray, tval());
      end else begin
        n = m_stk[ray].size();
        r = req_pop(ray, int'(m_wptr[ray]), n, tval());
        if (n > 0) m_wptr[ray] = m_wptr[ray] - 2'd1;
      end
      r.ray_info.is_shadow = 1'($urandom_range(0, 1));
      send(r);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_mode = 1'b0;
    ss_to_tarb_stall = 1'b0;
    ss_to_shader_stall = 1'b0;
    begin
      int n;
      n = 0;
      while ((exp_tarb.size() != 0 || exp_shd.size() != 0) && n < 100) begin
        tick();
        n++;
      end
    end
    idle(3);
    chk("final_tarb_pending", 128'(exp_tarb.size()), 128'(0));
    chk("final_shd_pending", 128'(exp_shd.size()), 128'(0));
    chk("final_tarb_valid", 128'(ss_to_tarb_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
